// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with a valid qualifier and 1-cycle latency.
// Optional signed-overflow output is enabled by defining FULL_ADDER_OVF_EN.

module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  logic w_p;
  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & w_p);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);
  // w_c[i] is the carry into bit i; w_c[WIDTH] is the carry-out.
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_vld;

  assign w_c[0] = C;

  full_adder_cell u_cell [WIDTH-1:0] (
    .i_a  (A),
    .i_b  (B),
    .i_ci (w_c[WIDTH-1:0]),
    .o_s  (w_s),
    .o_co (w_c[WIDTH:1])
  );

  // Datapath flops load only on accepted inputs, so X on idle cycles never reaches them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_sum   <= w_s;
        r_carry <= w_c[WIDTH];
      end
    end
  end

  assign sum       = r_sum;
  assign carry     = r_carry;
  assign out_valid = r_vld;

`ifdef FULL_ADDER_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n)        r_ovf <= 1'b0;
    else if (in_valid) r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
  end

  assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: WIDTH=1, 8 and 4 instances against an arithmetic reference model.
module tb_full_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v1, a1, b1, c1, s1, co1, ov1_vld;
  logic       v8, c8, co8, ov8_vld;
  logic [7:0] a8, b8, s8;
  logic       v4, c4, co4, ov4_vld;
  logic [3:0] a4, b4, s4;
`ifdef FULL_ADDER_OVF_EN
  logic ovf1, ovf8, ovf4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1), .C(c1),
    .sum(s1), .carry(co1), .out_valid(ov1_vld)
`ifdef FULL_ADDER_OVF_EN
    , .overflow(ovf1)
`endif
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8), .C(c8),
    .sum(s8), .carry(co8), .out_valid(ov8_vld)
`ifdef FULL_ADDER_OVF_EN
    , .overflow(ovf8)
`endif
  );

  full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .A(a4), .B(b4), .C(c4),
    .sum(s4), .carry(co4), .out_valid(ov4_vld)
`ifdef FULL_ADDER_OVF_EN
    , .overflow(ovf4)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer addition; signed overflow from the signed result range.
  function automatic longint unsigned ref_total(int w, longint unsigned a, longint unsigned b, bit c);
    return a + b + c;
  endfunction

  function automatic bit ref_ovf(int w, longint unsigned a, longint unsigned b, bit c);
    longint sa, sb, t, lim;
    lim = longint'(1) << (w - 1);
    sa = (a >= lim) ? longint'(a) - 2 * lim : longint'(a);
    sb = (b >= lim) ? longint'(b) - 2 * lim : longint'(b);
    t  = sa + sb + c;
    return (t >= lim) || (t < -lim);
  endfunction

  task automatic check8(input string tag, input longint unsigned a, input longint unsigned b, input bit c);
    longint unsigned t;
    t = ref_total(8, a, b, c);
    chk({tag, ".sum"},   s8,  t % 256);
    chk({tag, ".carry"}, co8, (t >> 8) & 1);
    chk({tag, ".vld"},   ov8_vld, 1);
`ifdef FULL_ADDER_OVF_EN
    chk({tag, ".ovf"},   ovf8, ref_ovf(8, a, b, c));
`endif
  endtask

  logic [1:0] tt_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    logic [2:0]  abc;
    logic [7:0]  ra, rb;
    logic [3:0]  qa, qb;
    logic        qc;
    longint unsigned t;

    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    v4 = 0; a4 = 0; b4 = 0; c4 = 0;

    // Reset with valid inputs pending: reset wins.
    rst_n = 0; v1 = 1; a1 = 1; b1 = 1; c1 = 1;
    tick(); tick();
    chk("rst.sum",   s1, 0);
    chk("rst.carry", co1, 0);
    chk("rst.vld",   ov1_vld, 0);
    chk("rst.vld8",  ov8_vld, 0);
    chk("rst.sum8",  s8, 0);
`ifdef FULL_ADDER_OVF_EN
    chk("rst.ovf",   ovf1, 0);
`endif

    rst_n = 1;
    tick();
    chk("rel.sum",   s1, 1);
    chk("rel.carry", co1, 1);
    chk("rel.vld",   ov1_vld, 1);

    // WIDTH=1 truth table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      a1 = abc[2]; b1 = abc[1]; c1 = abc[0];
      tick();
      chk($sformatf("tt%0d", i), {co1, s1}, tt_exp[i]);
      chk($sformatf("tt%0d.vld", i), ov1_vld, 1);
`ifdef FULL_ADDER_OVF_EN
      chk($sformatf("tt%0d.ovf", i), ovf1, ref_ovf(1, abc[2], abc[1], abc[0]));
`endif
    end

    // Hold behaviour, including X on idle operands.
    a1 = 0; b1 = 1; c1 = 0; v1 = 1;
    tick();
    chk("hold.acc", {co1, s1}, 2'b01);
    v1 = 0; a1 = 1; b1 = 1; c1 = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin a1 = 1'bx; b1 = 1'bx; c1 = 1'bx; end
      tick();
      chk($sformatf("hold%0d", i), {co1, s1}, 2'b01);
      chk($sformatf("hold%0d.vld", i), ov1_vld, 0);
    end

    // WIDTH=8 directed wrap and overflow cases.
    v8 = 1;
    a8 = 8'hFF; b8 = 8'h00; c8 = 1; tick(); check8("w8.ff", 8'hFF, 8'h00, 1);
    chk("w8.ff.sum_const", s8, 8'h00);
    a8 = 8'h80; b8 = 8'h80; c8 = 0; tick(); check8("w8.80", 8'h80, 8'h80, 0);
    chk("w8.80.carry_const", co8, 1);
    a8 = 8'h12; b8 = 8'h34; c8 = 1; tick(); check8("w8.12", 8'h12, 8'h34, 1);
    chk("w8.12.sum_const", s8, 8'h47);
    a8 = 8'h7F; b8 = 8'h01; c8 = 0; tick(); check8("w8.7f", 8'h7F, 8'h01, 0);
    chk("w8.7f.sum_const", s8, 8'h80);
`ifdef FULL_ADDER_OVF_EN
    chk("w8.7f.ovf_const", ovf8, 1);
`endif
    a8 = 8'hFF; b8 = 8'h01; c8 = 0; tick(); check8("w8.ff01", 8'hFF, 8'h01, 0);
`ifdef FULL_ADDER_OVF_EN
    chk("w8.ff01.ovf_const", ovf8, 0);
`endif
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); qc = 1'($urandom);
      a8 = ra; b8 = rb; c8 = qc;
      tick();
      check8($sformatf("w8.rnd%0d", i), ra, rb, qc);
    end
    v8 = 0;
    tick();
    chk("w8.idle.vld", ov8_vld, 0);

    // WIDTH=4 back-to-back random stream.
    v4 = 1;
    for (int i = 0; i < 16; i++) begin
      qa = 4'($urandom); qb = 4'($urandom); qc = 1'($urandom);
      a4 = qa; b4 = qb; c4 = qc;
      tick();
      t = ref_total(4, qa, qb, qc);
      chk($sformatf("b2b%0d", i), {co4, s4}, t);
      chk($sformatf("b2b%0d.vld", i), ov4_vld, 1);
`ifdef FULL_ADDER_OVF_EN
      chk($sformatf("b2b%0d.ovf", i), ovf4, ref_ovf(4, qa, qb, qc));
`endif
    end

    // Mid-stream reset discards the in-flight result.
    a4 = 4'hF; b4 = 4'hF; c4 = 1; rst_n = 0;
    tick();
    chk("midrst.vld", ov4_vld, 0);
    chk("midrst.sum", {co4, s4}, 0);
    rst_n = 1; a4 = 4'h9; b4 = 4'h8; c4 = 0;
    tick();
    chk("postrst", {co4, s4}, 5'h11);
    chk("postrst.vld", ov4_vld, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/full_adder.md
# full_adder

Registered full adder: adds two WIDTH-bit operands plus a 1-bit carry-in and produces a WIDTH-bit sum and a carry-out one clock after the operands are accepted. Default WIDTH=1 gives a classic single-bit full adder with registered outputs. The block is a leaf arithmetic primitive for datapaths that need a clocked add with a valid qualifier. Internally it is a ripple chain of 1-bit full-adder cells feeding an output register.

## Interface

- WIDTH, 1, operand and sum width in bits; legal range 1..64.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  A/B/C qualify this cycle.
- A  input  WIDTH  operand A, unsigned (two's-complement when overflow is used).
- B  input  WIDTH  operand B.
- C  input  1  carry-in.
- sum  output  WIDTH  registered (A + B + C) mod 2^WIDTH.
- carry  output  1  registered carry-out, bit WIDTH of A + B + C.
- out_valid  output  1  sum/carry updated from an accepted input this cycle.
- overflow  output  1  signed overflow; present only with FULL_ADDER_OVF_EN.

## Operation

- Per-bit cell i: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])); c[0] = C.
- {carry, sum} = A + B + C, computed at full WIDTH+1 precision; no truncation except the sum wrap mod 2^WIDTH.
- On a clk edge with rst_n=1 and in_valid=1: register sum, carry (and overflow); out_valid <= 1.
- On a clk edge with rst_n=1 and in_valid=0: sum, carry, overflow hold their previous values; out_valid <= 0.
- Operands are unsigned for sum/carry. No saturation.
- X on inputs while in_valid=0 must not disturb outputs.

## Timing

- Reset: on a clk edge with rst_n=0: sum=0, carry=0, out_valid=0, overflow=0. Reset has priority over in_valid.
- Reset deasserting: the first edge with rst_n=1 and in_valid=1 produces valid output; no warm-up cycles.
- Latency: exactly 1 clock from accepting edge to visible output. Throughput: one add per clock, back-to-back with no bubbles.
- Input-to-register path is purely combinational; outputs are driven only from flops, so there are no combinational input-to-output paths.
- Reset asserted mid-stream discards any result being registered on that edge; out_valid is 0 on the following cycle.

## Configuration

- FULL_ADDER_OVF_EN defined:
  - overflow port exists.
  - Registered together with sum as c[WIDTH] ^ c[WIDTH-1] (signed two's-complement overflow).
  - Follows the same hold and reset rules as sum.
  - For WIDTH=1 the rule uses c[0]=C.
- FULL_ADDER_OVF_EN undefined:
  - overflow port and its flop are absent.
  - All other behaviour is identical.

## Test plan

- WIDTH=1 truth table:
  - Apply all 8 {A,B,C} combinations 000..111 with in_valid=1.
  - One cycle later {carry,sum} must read 00,01,01,10,01,10,10,11 respectively.
- Reset:
  - Drive A=1, B=1, C=1, in_valid=1 with rst_n=0 for 2 edges -> sum=0, carry=0, out_valid=0.
  - Release rst_n -> next edge gives sum=1, carry=1, out_valid=1.
- Hold:
  - Accept A=0, B=1, C=0 -> sum=1, carry=0.
  - Then in_valid=0 with A=1, B=1, C=1 for 3 cycles -> sum=1, carry=0 held; out_valid=0.
- WIDTH=8 wrap:
  - A=0xFF, B=0x00, C=1 -> sum=0x00, carry=1.
  - A=0x80, B=0x80, C=0 -> sum=0x00, carry=1.
  - A=0x12, B=0x34, C=1 -> sum=0x47, carry=0.
- Overflow (FULL_ADDER_OVF_EN, WIDTH=8):
  - A=0x7F, B=0x01, C=0 -> sum=0x80, overflow=1.
  - A=0xFF, B=0x01, C=0 -> sum=0x00, carry=1, overflow=0.
- Back-to-back:
  - WIDTH=4, 16 random operand pairs on consecutive cycles with in_valid=1.
  - Each result must appear exactly 1 cycle later, out_valid=1 continuously, and match the reference sum A+B+C.
